// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and helpers for the convolution control sequencer:
//            FSM state codes, array latency and output-dimension helpers.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Pixel-read to result-available latency of a K x K systolic array.
  function automatic int conv_lat(input int k);
    return 2 * k - 1;
  endfunction

  // Valid ("no padding") output dimension for one image axis.
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_ctrl_if
// Brief    : Control/status and buffer-strobe bundle between the convolution
//            sequencer (master) and the datapath / host side (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface conv_seq_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [2:0]        state;
  logic [2:0]        next_state;
  logic              pe_clear;
  logic              w_load_en;
  logic [ADDR_W-1:0] w_addr;
  logic              x_rd_en;
  logic [ADDR_W-1:0] x_addr;
  logic              y_wr_en;
  logic [ADDR_W-1:0] y_addr;

  modport master (
    input  start, abort,
    output busy, done, state, next_state, pe_clear,
           w_load_en, w_addr, x_rd_en, x_addr, y_wr_en, y_addr
  );

  modport slave (
    output start, abort,
    input  busy, done, state, next_state, pe_clear,
           w_load_en, w_addr, x_rd_en, x_addr, y_wr_en, y_addr
  );
endinterface
`default_nettype wire

// File: rtl/valid_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : valid_delay_line
// Brief    : DEPTH-stage shift register carrying the per-read "result valid"
//            bit through the array latency; synchronous flush empties it.
// Revision : 1.0 - initial release
// ============================================================================
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic din_i,
  output logic dout_o
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_single
      // Single stage: the valid bit simply lands one cycle later.
      always_ff @(posedge clk) begin
        if (rst || flush_i) sr_q <= '0;
        else                sr_q <= din_i;
      end
    end else begin : g_multi
      // Shift toward the MSB; the MSB is the retiring result.
      always_ff @(posedge clk) begin
        if (rst || flush_i) sr_q <= '0;
        else                sr_q <= {sr_q[DEPTH-2:0], din_i};
      end
    end
  endgenerate

  assign dout_o = sr_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_ctrl
// Brief    : Per-frame sequencer for a K x K systolic convolution array:
//            clear PEs, load K*K weights, stream IMG_W*IMG_H pixels, drain the
//            array latency and write back only fully-covered output pixels.
// Revision : 1.0 - initial release
// ============================================================================
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int K      = 3,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 8,
  parameter int LAT    = conv_lat(K)
) (
  input logic             clk,
  input logic             rst,
  conv_seq_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(K * K - 1);
  localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] KM1      = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [3:0]        D_LAST   = 4'(LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] w_cnt_q, x_cnt_q, row_q, col_q, y_cnt_q;
  logic [3:0]        d_cnt_q;

  logic busy, done, pe_clear, w_load_en, x_rd_en, y_wr_en, valid_in;

  // State register; reset and abort both land in IDLE.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection and state-decoded strobes.
  always_comb begin
    state_d   = state_q;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    pe_clear  = (state_q == ST_CLEAR);
    w_load_en = (state_q == ST_LOAD_W);
    x_rd_en   = (state_q == ST_STREAM);
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_LOAD_W;
      ST_LOAD_W: if (w_cnt_q == W_LAST) state_d = ST_STREAM;
      ST_STREAM: if (x_cnt_q == X_LAST) state_d = ST_DRAIN;
      ST_DRAIN:  if (d_cnt_q == D_LAST) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a start seen in IDLE.
    if (bus.abort) state_d = ST_IDLE;
  end

  // Weight, pixel, row/col, drain and output counters; CLEAR rearms them.
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_CLEAR) begin
      w_cnt_q <= '0;
      x_cnt_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      d_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      if (state_q == ST_LOAD_W && w_cnt_q != W_LAST) w_cnt_q <= w_cnt_q + ONE_A;
      if (state_q == ST_STREAM && x_cnt_q != X_LAST) begin
        x_cnt_q <= x_cnt_q + ONE_A;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + ONE_A;
        end else begin
          col_q <= col_q + ONE_A;
        end
      end
      if (state_q == ST_DRAIN && d_cnt_q != D_LAST) d_cnt_q <= d_cnt_q + 4'd1;
      if (y_wr_en) y_cnt_q <= y_cnt_q + ONE_A;
    end
  end

  // Only windows fully inside the image produce a stored result.
  assign valid_in = x_rd_en && (row_q >= KM1) && (col_q >= KM1);

  valid_delay_line #(
    .DEPTH (LAT)
  ) u_valid_dl (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.abort),
    .din_i   (valid_in),
    .dout_o  (y_wr_en)
  );

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.state      = state_q;
  assign bus.next_state = state_d;
  assign bus.pe_clear   = pe_clear;
  assign bus.w_load_en  = w_load_en;
  assign bus.w_addr     = w_cnt_q;
  assign bus.x_rd_en    = x_rd_en;
  assign bus.x_addr     = x_cnt_q;
  assign bus.y_wr_en    = y_wr_en;
  assign bus.y_addr     = y_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_seq_ctrl
// Brief    : Scoreboard bench for conv_seq_ctrl with a K=3 8x8 instance and a
//            K=1 4x4 instance; expected strobe/address/cycle tuples are queued
//            when frames are launched and retired as the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_seq_ctrl;
  import conv_pkg::*;

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb [8][$];
  string       kname [4] = '{"wld", "rd", "wr", "done"};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_seq_ctrl_if #(.ADDR_W(8)) ifa ();
  conv_seq_ctrl_if #(.ADDR_W(8)) ifb ();

  conv_seq_ctrl #(.K(3), .IMG_W(8), .IMG_H(8), .ADDR_W(8)) u_dut_a (
    .clk (clk), .rst (rst), .bus (ifa.master)
  );
  conv_seq_ctrl #(.K(1), .IMG_W(4), .IMG_H(4), .ADDR_W(8)) u_dut_b (
    .clk (clk), .rst (rst), .bus (ifb.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // idx = dut*4 + kind; kind 0 weight load, 1 read, 2 write, 3 done.
  task automatic observe(input int idx, input logic en, input logic [31:0] addr);
    exp_t  e;
    string tag;
    tag = $sformatf("%s_%s", (idx < 4) ? "a" : "b", kname[idx % 4]);
    if (en === 1'b1) begin
      if (sb[idx].size() == 0) begin
        chk({tag, "_unexpected"}, 32'(en), 32'd0);
      end else begin
        e = sb[idx].pop_front();
        chk({tag, "_cyc"}, cyc, e.cyc);
        if (idx % 4 != 3) chk({tag, "_addr"}, addr, e.addr);
      end
    end
  endtask

  always @(negedge clk) begin
    observe(0, ifa.w_load_en, 32'(ifa.w_addr));
    observe(1, ifa.x_rd_en,   32'(ifa.x_addr));
    observe(2, ifa.y_wr_en,   32'(ifa.y_addr));
    observe(3, ifa.done,      32'd0);
    observe(4, ifb.w_load_en, 32'(ifb.w_addr));
    observe(5, ifb.x_rd_en,   32'(ifb.x_addr));
    observe(6, ifb.y_wr_en,   32'(ifb.y_addr));
    observe(7, ifb.done,      32'd0);
  end

  // e0 = value of cyc right after the edge that samples start (CLEAR cycle).
  task automatic push_frame(input int d, input int k, input int w, input int h,
                            input int unsigned e0);
    int unsigned kk, n, lat, yi;
    kk = k * k; n = w * h; lat = 2 * k - 1; yi = 0;
    for (int j = 0; j < int'(kk); j++) sb[d*4+0].push_back('{e0 + 1 + j, j});
    for (int i = 0; i < int'(n); i++) begin
      sb[d*4+1].push_back('{e0 + 1 + kk + i, i});
      if ((i / w) >= k - 1 && (i % w) >= k - 1) begin
        sb[d*4+2].push_back('{e0 + 1 + kk + i + lat, yi});
        yi++;
      end
    end
    sb[d*4+3].push_back('{e0 + 1 + kk + n + lat, 0});
  endtask

  function automatic int unsigned done_cyc(input int k, input int w, input int h,
                                           input int unsigned e0);
    return e0 + 1 + k * k + w * h + 2 * k - 1;
  endfunction

  // Drop every expectation of DUT d scheduled after cycle ca.
  task automatic prune(input int d, input int unsigned ca);
    for (int q = d * 4; q < d * 4 + 4; q++) begin
      exp_t keep[$];
      for (int j = 0; j < sb[q].size(); j++)
        if (sb[q][j].cyc <= ca) keep.push_back(sb[q][j]);
      sb[q] = keep;
    end
  endtask

  task automatic chk_left(input string tag, input int d);
    for (int q = d * 4; q < d * 4 + 4; q++)
      chk($sformatf("%s_left_%s", tag, kname[q % 4]), 32'(sb[q].size()), 32'd0);
  endtask

  task automatic chk_idle(input string tag, input logic [2:0] st, input logic b,
                          input logic dn, input logic pc, input logic wl,
                          input logic xr, input logic yw, input logic [7:0] wa,
                          input logic [7:0] xa, input logic [7:0] ya);
    chk({tag, "_state"}, 32'(st), 32'd0);
    chk({tag, "_busy"},  32'(b),  32'd0);
    chk({tag, "_done"},  32'(dn), 32'd0);
    chk({tag, "_pecl"},  32'(pc), 32'd0);
    chk({tag, "_wld"},   32'(wl), 32'd0);
    chk({tag, "_xrd"},   32'(xr), 32'd0);
    chk({tag, "_ywr"},   32'(yw), 32'd0);
    chk({tag, "_waddr"}, 32'(wa), 32'd0);
    chk({tag, "_xaddr"}, 32'(xa), 32'd0);
    chk({tag, "_yaddr"}, 32'(ya), 32'd0);
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic launch_a(output int unsigned e0);
    e0 = cyc + 1;
    ifa.start = 1'b1;
    push_frame(0, 3, 8, 8, e0);
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  initial begin
    int unsigned e0, e1, ed, ca;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("a_rst", ifa.state, ifa.busy, ifa.done, ifa.pe_clear, ifa.w_load_en,
             ifa.x_rd_en, ifa.y_wr_en, ifa.w_addr, ifa.x_addr, ifa.y_addr);
    chk_idle("b_rst", ifb.state, ifb.busy, ifb.done, ifb.pe_clear, ifb.w_load_en,
             ifb.x_rd_en, ifb.y_wr_en, ifb.w_addr, ifb.x_addr, ifb.y_addr);
    rst = 1'b0;
    @(negedge clk);

    // Nominal K=3 8x8 frame.
    launch_a(e0);
    chk("a_clear_state", 32'(ifa.state), 32'd1);
    chk("a_clear_pulse", 32'(ifa.pe_clear), 32'd1);
    ed = done_cyc(3, 8, 8, e0);
    wait_cyc(ed + 1);
    chk("a_busy_after_done", 32'(ifa.busy), 32'd0);
    chk("a_state_after_done", 32'(ifa.state), 32'd0);
    chk_left("a_nom", 0);

    // K=1 4x4 frame: LAT=1.
    e0 = cyc + 1;
    ifb.start = 1'b1;
    push_frame(1, 1, 4, 4, e0);
    @(negedge clk);
    ifb.start = 1'b0;
    wait_cyc(done_cyc(1, 4, 4, e0) + 2);
    chk_left("b_nom", 1);

    // Abort on the 10th STREAM cycle, then a clean frame.
    launch_a(e0);
    ca = e0 + 1 + 9 + 9;
    wait_cyc(ca);
    ifa.abort = 1'b1;
    prune(0, ca);
    @(negedge clk);
    ifa.abort = 1'b0;
    chk("abort_state", 32'(ifa.state), 32'd0);
    chk("abort_busy", 32'(ifa.busy), 32'd0);
    repeat (20) @(negedge clk);
    chk_left("a_abort", 0);
    launch_a(e0);
    wait_cyc(done_cyc(3, 8, 8, e0) + 2);
    chk_left("a_post_abort", 0);

    // Reset asserted for one cycle during DRAIN.
    launch_a(e0);
    ca = e0 + 1 + 9 + 64 + 1;
    wait_cyc(ca);
    chk("rst_in_drain", 32'(ifa.state), 32'd4);
    rst = 1'b1;
    prune(0, ca);
    @(negedge clk);
    chk_idle("a_rst_drain", ifa.state, ifa.busy, ifa.done, ifa.pe_clear, ifa.w_load_en,
             ifa.x_rd_en, ifa.y_wr_en, ifa.w_addr, ifa.x_addr, ifa.y_addr);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_left("a_rst_drain", 0);

    // start held high: back-to-back frames with one IDLE cycle between.
    e0 = cyc + 1;
    ifa.start = 1'b1;
    push_frame(0, 3, 8, 8, e0);
    ed = done_cyc(3, 8, 8, e0);
    e1 = ed + 2;
    push_frame(0, 3, 8, 8, e1);
    wait_cyc(ed + 1);
    chk("b2b_idle_gap", 32'(ifa.state), 32'd0);
    @(negedge clk);
    chk("b2b_restart", 32'(ifa.state), 32'd1);
    ifa.start = 1'b0;
    wait_cyc(done_cyc(3, 8, 8, e1) + 2);
    chk_left("a_b2b", 0);

    // start and abort together in IDLE.
    ifa.start = 1'b1;
    ifa.abort = 1'b1;
    @(negedge clk);
    chk("start_abort_state", 32'(ifa.state), 32'd0);
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    repeat (3) @(negedge clk);

    // Illegal state code recovers to IDLE.
    force u_dut_a.state_q = state_e'(3'd6);
    #1;
    chk("illegal_next", 32'(ifa.next_state), 32'd0);
    release u_dut_a.state_q;
    @(negedge clk);
    chk("illegal_recover", 32'(ifa.state), 32'd0);

    repeat (5) @(negedge clk);
    chk_left("final_a", 0);
    chk_left("final_b", 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
